// File: rtl/clock_pkg.sv
// Shared types and constants for the HH:MM clock: edit states, BCD digit pairs,
// range limits, blink masks and wrap-around BCD increment/decrement helpers.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } bcd2_t;

  localparam int MAX_HR  = 23;
  localparam int MAX_MIN = 59;

  localparam logic [3:0] BK_HR   = 4'b1100;
  localparam logic [3:0] BK_MIN  = 4'b0011;
  localparam logic [3:0] BK_NONE = 4'b0000;

  localparam bcd2_t HR_MAX_BCD  = {4'(MAX_HR / 10), 4'(MAX_HR % 10)};
  localparam bcd2_t MIN_MAX_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

  // Two-digit BCD +1 wrapping from max back to 00.
  function automatic bcd2_t bcd_inc(input bcd2_t v, input bcd2_t max);
    bcd2_t r;
    r = v;
    if (v == max) begin
      r = '0;
    end else if (v.units == 4'd9) begin
      r.tens  = v.tens + 4'd1;
      r.units = 4'd0;
    end else begin
      r.units = v.units + 4'd1;
    end
    return r;
  endfunction

  // Two-digit BCD -1 wrapping from 00 up to max.
  function automatic bcd2_t bcd_dec(input bcd2_t v, input bcd2_t max);
    bcd2_t r;
    r = v;
    if (v == '0) begin
      r = max;
    end else if (v.units == 4'd0) begin
      r.tens  = v.tens - 4'd1;
      r.units = 4'd9;
    end else begin
      r.units = v.units - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, and a single
// 1-cycle pulse on each accepted press (rising edge of the stable level).
module btn_debounce #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          meta;
  logic          sync;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      meta  <= raw;
      sync  <= meta;
      pulse <= 1'b0;
      // Any return to the stable level restarts the stability window.
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        stable <= sync;
        cnt    <= '0;
        pulse  <= sync;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clock_time_setter.sv
// HH:MM timekeeper with button-driven hour/minute editing; emits BCD digits
// (dig0 = minutes units) plus per-digit blink enables for the display driver.
module clock_time_setter
  import clock_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] bk,
  output logic       editing
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic          mode_p;
  logic          inc_p;
  logic          dec_p;
  state_t        state;
  bcd2_t         hr;
  bcd2_t         mn;
  logic [PW-1:0] presc;
  logic [5:0]    sec;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
    .clock(clock), .reset(reset), .raw(btn_mode), .pulse(mode_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
    .clock(clock), .reset(reset), .raw(btn_inc), .pulse(inc_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dec (
    .clock(clock), .reset(reset), .raw(btn_dec), .pulse(dec_p)
  );

  assign dig0 = mn.units;
  assign dig1 = mn.tens;
  assign dig2 = hr.units;
  assign dig3 = hr.tens;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      hr      <= '0;
      mn      <= '0;
      presc   <= '0;
      sec     <= '0;
      bk      <= BK_NONE;
      editing <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          // Time advances in the same cycle a mode press leaves RUN.
          if (presc == PW'(CLK_HZ - 1)) begin
            presc <= '0;
            if (sec == 6'd59) begin
              sec <= '0;
              mn  <= bcd_inc(mn, MIN_MAX_BCD);
              if (mn == MIN_MAX_BCD) hr <= bcd_inc(hr, HR_MAX_BCD);
            end else begin
              sec <= sec + 6'd1;
            end
          end else begin
            presc <= presc + PW'(1);
          end
          if (mode_p) begin
            state   <= SET_HR;
            bk      <= BK_HR;
            editing <= 1'b1;
          end
        end
        SET_HR: begin
          if (inc_p && !dec_p)      hr <= bcd_inc(hr, HR_MAX_BCD);
          else if (dec_p && !inc_p) hr <= bcd_dec(hr, HR_MAX_BCD);
          if (mode_p) begin
            state <= SET_MIN;
            bk    <= BK_MIN;
          end
        end
        SET_MIN: begin
          if (inc_p && !dec_p)      mn <= bcd_inc(mn, MIN_MAX_BCD);
          else if (dec_p && !inc_p) mn <= bcd_dec(mn, MIN_MAX_BCD);
          if (mode_p) begin
            state   <= RUN;
            bk      <= BK_NONE;
            editing <= 1'b0;
            presc   <= '0;
            sec     <= '0;
          end
        end
        default: begin
          state   <= RUN;
          bk      <= BK_NONE;
          editing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_time_setter.sv
// Scoreboard bench for clock_time_setter: every visible output change is popped
// against a hand-computed expected snapshot; timing and debounce checked directly.
module tb_clock_time_setter;
  import clock_pkg::*;

  localparam int DEB = 4;
  localparam int MODE = 0, INC = 1, DEC = 2, BOTH = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [3:0] dig0, dig1, dig2, dig3, bk;
  logic       editing;

  clock_time_setter #(.CLK_HZ(10), .DEB_CYCLES(DEB)) dut (
    .clock(clock), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .btn_dec(btn_dec), .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .bk(bk), .editing(editing)
  );

  // ---- clock / cycle counter ----
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---- scoreboard state ----
  int          checks = 0;
  int          errors = 0;
  logic [20:0] exp_q[$];
  logic [20:0] prev = '0;
  int          last_chg = 0;
  int          inc_pulses = 0;
  int          inc_pulse_cyc = 0;
  logic [20:0] cur;
  assign cur = {dig3, dig2, dig1, dig0, bk, editing};

  function automatic logic [20:0] snap(input int hh, input int mm,
                                       input logic [3:0] b, input logic e);
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), b, e};
  endfunction

  // Monitor: each output change must match the oldest queued expectation.
  always @(negedge clock) begin
    logic [20:0] e;
    if (cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got %h, required unchanged %h", cur, prev);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL out_change: got %h, required %h", cur, e);
        end
      end
      prev = cur;
      last_chg = cyc;
    end
  end

  always @(negedge clock) begin
    if (dut.u_inc.pulse === 1'b1) begin
      inc_pulses++;
      inc_pulse_cyc = cyc;
    end
  end

  // ---- driver / check tasks ----
  task automatic expect_out(input int hh, input int mm, input logic [3:0] b, input logic e);
    exp_q.push_back(snap(hh, mm, b, e));
  endtask

  task automatic press(input int which);
    @(negedge clock);
    btn_mode = (which == MODE);
    btn_inc  = (which == INC) || (which == BOTH);
    btn_dec  = (which == DEC) || (which == BOTH);
    repeat (DEB + 4) @(negedge clock);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    repeat (DEB + 4) @(negedge clock);
  endtask

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic check_out(input string name, input int hh, input int mm,
                           input logic [3:0] b, input logic e);
    logic [20:0] req;
    req = snap(hh, mm, b, e);
    checks++;
    if (cur !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, cur, req);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // ---- stimulus ----
  initial begin
    int t0, p0, rl;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check_out("reset_state", 0, 0, BK_NONE, 1'b0);

    // 3-cycle glitch is rejected
    p0 = inc_pulses;
    @(negedge clock);
    btn_inc = 1'b1;
    repeat (3) @(negedge clock);
    btn_inc = 1'b0;
    repeat (10) @(negedge clock);
    check("glitch_pulses", inc_pulses - p0, 0);

    // 10-cycle hold: one pulse, 6 cycles after press
    p0 = inc_pulses;
    @(negedge clock);
    t0 = cyc;
    btn_inc = 1'b1;
    repeat (10) @(negedge clock);
    btn_inc = 1'b0;
    repeat (10) @(negedge clock);
    check("hold_pulses", inc_pulses - p0, 1);
    check("press_latency", inc_pulse_cyc - t0, 6);

    // preset 23:59 and let it roll over
    expect_out(0, 0, BK_HR, 1'b1);    press(MODE);
    expect_out(23, 0, BK_HR, 1'b1);   press(DEC);
    expect_out(23, 0, BK_MIN, 1'b1);  press(MODE);
    expect_out(23, 59, BK_MIN, 1'b1); press(DEC);
    expect_out(23, 59, BK_NONE, 1'b0); press(MODE);
    wait_drain("preset_drain", 20);
    rl = last_chg;
    expect_out(0, 0, BK_NONE, 1'b0);
    wait_drain("rollover_drain", 700);
    check("rollover_600", last_chg - rl, 600);

    // hour edit
    expect_out(0, 0, BK_HR, 1'b1);  press(MODE);
    expect_out(23, 0, BK_HR, 1'b1); press(DEC);
    expect_out(0, 0, BK_HR, 1'b1);  press(INC);
    expect_out(1, 0, BK_HR, 1'b1);  press(INC);
    wait_drain("hour_edit_drain", 20);
    check_out("hour_edit", 1, 0, BK_HR, 1'b1);

    // frozen while editing, and simultaneous inc/dec cancel
    repeat (1000) @(negedge clock);
    check_out("freeze", 1, 0, BK_HR, 1'b1);
    press(BOTH);
    check_out("inc_dec_same", 1, 0, BK_HR, 1'b1);

    // minute edit: wrap without carry, then exact minute timing in RUN
    expect_out(1, 0, BK_MIN, 1'b1);  press(MODE);
    expect_out(1, 59, BK_MIN, 1'b1); press(DEC);
    expect_out(1, 0, BK_MIN, 1'b1);  press(INC);
    wait_drain("min_edit_drain", 20);
    check_out("min_wrap_no_carry", 1, 0, BK_MIN, 1'b1);
    expect_out(1, 0, BK_NONE, 1'b0); press(MODE);
    wait_drain("run_entry_drain", 20);
    rl = last_chg;
    expect_out(1, 1, BK_NONE, 1'b0);
    wait_drain("minute_tick_drain", 700);
    check("minute_600", last_chg - rl, 600);

    // set 12:34, then async reset mid-edit
    expect_out(1, 1, BK_HR, 1'b1); press(MODE);
    for (int k = 2; k <= 12; k++) begin
      expect_out(k, 1, BK_HR, 1'b1);
      press(INC);
    end
    expect_out(12, 1, BK_MIN, 1'b1); press(MODE);
    for (int k = 2; k <= 34; k++) begin
      expect_out(12, k, BK_MIN, 1'b1);
      press(INC);
    end
    wait_drain("set_1234_drain", 20);
    check_out("at_1234", 12, 34, BK_MIN, 1'b1);
    expect_out(0, 0, BK_NONE, 1'b0);
    @(posedge clock);
    #3 reset = 1'b0;
    #1 check_out("async_reset", 0, 0, BK_NONE, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    wait_drain("final_drain", 10);
    repeat (20) @(negedge clock);
    check_out("post_reset", 0, 0, BK_NONE, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
